// File: rtl/dmem_responder.sv
// Byte-addressed, big-endian data store behind a valid/ready request/response
// handshake with a fixed access latency. Define DMEM_STATS_EN to add access counters.
module dmem_responder #(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [3:0]  req_size,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0] stat_reads,
    output logic [31:0] stat_writes,
    output logic [31:0] stat_errs
`endif
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   count;
    logic            lat_write;
    logic [63:0]     lat_addr;
    logic [63:0]     lat_wdata;
    logic [3:0]      lat_size;
    logic [7:0]      mem [DEPTH_BYTES];

    logic            accept, enter_resp, rsp_hs;
    logic            size_ok, misaligned, out_of_range, req_err;
    logic [3:0]      size_gap;
    logic [6:0]      shamt;
    logic [AW-1:0]   base;
    logic [63:0]     wword, rword, rdata_aligned;

    assign accept     = req_valid && req_ready;
    assign enter_resp = (state == BUSY) && (count == '0);
    assign rsp_hs     = rsp_valid && rsp_ready;

    // Range check is split in two so A+S never wraps at 64 bits.
    assign size_ok      = (lat_size == 4'd1) || (lat_size == 4'd2) ||
                          (lat_size == 4'd4) || (lat_size == 4'd8);
    assign misaligned   = (lat_addr & (64'(lat_size) - 64'd1)) != 64'd0;
    assign out_of_range = (lat_addr >= 64'(DEPTH_BYTES)) ||
                          (lat_addr > 64'(DEPTH_BYTES) - 64'(lat_size));
    assign req_err      = !size_ok || misaligned || out_of_range;

    // Left-justify store data so byte A always sits in bits [63:56].
    assign size_gap = 4'd8 - lat_size;
    assign shamt    = {size_gap, 3'b000};
    assign base     = lat_addr[AW-1:0];
    assign wword    = lat_wdata << shamt;

    always_comb begin
        rword = '0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < lat_size)
                rword[63-8*i -: 8] = mem[base + AW'(i)];
        end
        rdata_aligned = rword >> shamt;
    end

    // NOTE: the storage array has no reset branch so it maps onto plain RAM; contents are undefined after power-up.
    always_ff @(posedge clk) begin
        if (enter_resp && lat_write && !req_err) begin
            for (int i = 0; i < 8; i++) begin
                if (4'(i) < lat_size)
                    mem[base + AW'(i)] <= wword[63-8*i -: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY:    if (count == '0) state_nxt = RESP;
            RESP:    if (rsp_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_size  <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                lat_write <= req_write;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_size  <= req_size;
                count     <= CW'(LATENCY - 1);
            end else if (state == BUSY && count != '0) begin
                count <= count - 1'b1;
            end

            if (enter_resp) begin
                rsp_err   <= req_err;
                rsp_rdata <= (!lat_write && !req_err) ? rdata_aligned : 64'd0;
            end else if (rsp_hs) begin
                rsp_err   <= 1'b0;
                rsp_rdata <= '0;
            end
        end
    end

`ifdef DMEM_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_reads  <= '0;
            stat_writes <= '0;
            stat_errs   <= '0;
        end else if (enter_resp) begin
            if (req_err) begin
                if (stat_errs != '1) stat_errs <= stat_errs + 1'b1;
            end else if (lat_write) begin
                if (stat_writes != '1) stat_writes <= stat_writes + 1'b1;
            end else begin
                if (stat_reads != '1) stat_reads <= stat_reads + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder: a byte-array reference model
// produces expected responses that a separate monitor compares on each handshake.
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [63:0] req_addr, req_wdata;
    logic [3:0]  req_size;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [63:0] rsp_rdata;
`ifdef DMEM_STATS_EN
    logic [31:0] stat_reads, stat_writes, stat_errs;
`endif

    dmem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_size  (req_size),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
`ifdef DMEM_STATS_EN
        ,
        .stat_reads  (stat_reads),
        .stat_writes (stat_writes),
        .stat_errs   (stat_errs)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mm [DEPTH];
    int         n_vec = 0;
    int         n_err = 0;
    int         last_accept = 0;
    int         last_hs = 0;
    int         n_rd = 0, n_wr = 0, n_er = 0;
    bit         rr_force = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: byte array, big-endian, errors from the plain arithmetic rules.
    task automatic model(input bit w, input logic [63:0] a, input logic [63:0] d,
                         input logic [3:0] s, output logic [63:0] rd, output logic er);
        int sz;
        sz = int'(s);
        rd = 64'd0;
        er = 1'b0;
        if (!(sz == 1 || sz == 2 || sz == 4 || sz == 8)) er = 1'b1;
        else if (a % 64'(sz) != 0) er = 1'b1;
        else if (a >= 64'(DEPTH)) er = 1'b1;
        else if (a > 64'(DEPTH) - 64'(sz)) er = 1'b1;
        if (!er) begin
            for (int i = 0; i < sz; i++) begin
                if (w) mm[int'(a) + i] = d[8*(sz-1-i) +: 8];
                else   rd = (rd << 8) | 64'(mm[int'(a) + i]);
            end
        end
    endtask

    task automatic issue(input bit w, input logic [63:0] a, input logic [63:0] d,
                         input logic [3:0] s, input bit fixed,
                         input logic [63:0] f_rdata, input bit f_err);
        exp_t e;
        int   k;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_size  = s;
        k = 0;
        while (!req_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL issue_timeout: req_ready stayed %b (cycle %0d)", req_ready, cyc);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid   = 1'b0;
        last_accept = cyc;
        model(w, a, d, s, e.rdata, e.err);
        if (fixed) begin
            e.rdata = f_rdata;
            e.err   = f_err;
        end
        e.acc = cyc;
        if (e.err) n_er++;
        else if (w) n_wr++;
        else n_rd++;
        sb.push_back(e);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((sb.size() != 0 || rsp_valid) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
        end
    endtask

    // Monitor: latency on first rsp_valid, data/err on each handshake.
    initial begin
        exp_t e;
        bit   pv;
        pv = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
            end else begin
                if (rsp_valid && !pv) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_rsp: rsp_valid=1 with no outstanding request (cycle %0d)", cyc);
                    end else begin
                        check("latency", 64'(cyc - sb[0].acc), 64'(LAT));
                    end
                end
                if (rsp_valid && rsp_ready && sb.size() != 0) begin
                    e = sb.pop_front();
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", 64'(rsp_err), 64'(e.err));
                    last_hs = cyc + 1;
                end
                pv = rsp_valid;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (!rr_force) rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] held, a;
        logic [3:0]  s;
        int          acc2, r, wait_k;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_size  = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_req_ready", 64'(req_ready), 64'd1);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_rdata", rsp_rdata, 64'd0);
        check("reset_rsp_err", 64'(rsp_err), 64'd0);
`ifdef DMEM_STATS_EN
        check("reset_stat_reads", 64'(stat_reads), 64'd0);
`endif
        rst = 1'b0;

        // Fill the whole array so every later load has a known expectation.
        rr_force = 1'b0;
        for (int i = 0; i < DEPTH / 8; i++)
            issue(1'b1, 64'(i * 8), {$urandom, $urandom}, 4'd8, 1'b0, '0, 1'b0);
        drain();

        rr_force  = 1'b1;
        rsp_ready = 1'b1;
        issue(1'b1, 64'h10, 64'h0123456789ABCDEF, 4'd8, 1'b1, 64'd0, 1'b0);
        issue(1'b0, 64'h10, 64'd0, 4'd8, 1'b1, 64'h0123456789ABCDEF, 1'b0);
        issue(1'b0, 64'h10, 64'd0, 4'd1, 1'b1, 64'h01, 1'b0);
        issue(1'b0, 64'h16, 64'd0, 4'd2, 1'b1, 64'hCDEF, 1'b0);
        issue(1'b0, 64'h14, 64'd0, 4'd4, 1'b1, 64'h89ABCDEF, 1'b0);

        issue(1'b0, 64'h12, 64'd0, 4'd4, 1'b1, 64'd0, 1'b1);
        issue(1'b0, 64'h10, 64'd0, 4'd3, 1'b1, 64'd0, 1'b1);
        issue(1'b1, 64'(DEPTH - 4), 64'hDEADBEEFDEADBEEF, 4'd8, 1'b1, 64'd0, 1'b1);
        issue(1'b1, 64'hFFFFFFFFFFFFFFF8, 64'hDEADBEEFDEADBEEF, 4'd8, 1'b1, 64'd0, 1'b1);
        issue(1'b0, 64'h10, 64'd0, 4'd8, 1'b1, 64'h0123456789ABCDEF, 1'b0);
        issue(1'b0, 64'(DEPTH - 8), 64'd0, 4'd8, 1'b0, '0, 1'b0);
        drain();

        // Backpressure with a second request waiting.
        @(posedge clk);
        #2;
        rsp_ready = 1'b0;
        issue(1'b0, 64'h10, 64'd0, 4'd8, 1'b1, 64'h0123456789ABCDEF, 1'b0);
        acc2 = 0;
        fork
            begin
                issue(1'b0, 64'h14, 64'd0, 4'd4, 1'b1, 64'h89ABCDEF, 1'b0);
                acc2 = last_accept;
            end
            begin
                wait_k = 0;
                while (!rsp_valid && wait_k < 50) begin
                    @(negedge clk);
                    wait_k++;
                end
                check("bp_rsp_seen", 64'(rsp_valid), 64'd1);
                held = rsp_rdata;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
                    check("bp_rsp_rdata", rsp_rdata, held);
                    check("bp_req_ready", 64'(req_ready), 64'd0);
                end
                @(posedge clk);
                #2;
                rsp_ready = 1'b1;
            end
        join
        check("bp_second_accept", 64'(acc2), 64'(last_hs + 1));
        drain();

        // Reset while a store is in flight discards it.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 64'h20;
        req_wdata = 64'hFFFFFFFFFFFFFFFF;
        req_size  = 4'd8;
        wait_k = 0;
        while (!req_ready && wait_k < 50) begin
            @(negedge clk);
            wait_k++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_req_ready", 64'(req_ready), 64'd1);
        check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("midrst_rsp_rdata", rsp_rdata, 64'd0);
        check("midrst_rsp_err", 64'(rsp_err), 64'd0);
`ifdef DMEM_STATS_EN
        check("midrst_stat_reads", 64'(stat_reads), 64'd0);
        check("midrst_stat_writes", 64'(stat_writes), 64'd0);
        check("midrst_stat_errs", 64'(stat_errs), 64'd0);
`endif
        n_rd = 0;
        n_wr = 0;
        n_er = 0;
        @(negedge clk);
        rst = 1'b0;
        issue(1'b0, 64'h20, 64'd0, 4'd8, 1'b0, '0, 1'b0);
        drain();

        // Randomized mix of legal and illegal traffic under random backpressure.
        rr_force = 1'b0;
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 9));
            s = 4'(1 << $urandom_range(0, 3));
            if (r == 0) s = 4'($urandom_range(0, 15));
            a = 64'($urandom_range(0, DEPTH - 1));
            if (r != 1 && (s == 4'd1 || s == 4'd2 || s == 4'd4 || s == 4'd8))
                a = a - (a % 64'(s));
            if (r == 2) a = 64'(DEPTH) - 64'($urandom_range(0, 16));
            if (r == 3) a = {$urandom, $urandom};
            issue(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, s, 1'b0, '0, 1'b0);
        end
        drain();

`ifdef DMEM_STATS_EN
        check("stat_reads", 64'(stat_reads), 64'(n_rd));
        check("stat_writes", 64'(stat_writes), 64'(n_wr));
        check("stat_errs", 64'(stat_errs), 64'(n_er));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
